// File: rtl/msg_telemetry_responder.sv
// msg_telemetry_responder
//   Command decoder and telemetry reply streamer between the UART RX/TX
//   blocks and the robot datapaths. Command bytes arriving on the RX strobe
//   either drive the waypoint/stop/begin controls, or request a
//   snapshot of one telemetry channel. That snapshot is returned as a framed
//   reply: header (command code), BYTES_PER_CH data bytes MSB first, and an
//   optional 8-bit additive checksum.
//
// Ports
//   MESSAGE_INTERPRETER_CLOCK_50     system clock
//   MESSAGE_INTERPRETER_RESET_InHigh asynchronous active-high reset
//   RX_VALID_In / RX_DATA_InBus      received command byte strobe / value
//   TLM_InBus                        CH_COUNT flat-packed telemetry channels
//   TX_DATA_OutBus / TX_VALID_Out /
//   TX_READY_In                      reply byte stream (valid/ready)
//   WAYSELECT_OutBus                 selected waypoint index
//   STOPSIGNAL_OutLow                stop level, active low
//   BEGINSIGNAL_OutLow               begin level, active low
//   BUSY_Out                         reply frame in progress
//   ERR_Out                          one-cycle pulse, unknown command
//   OVERRUN_Out                      one-cycle pulse, telemetry request dropped
module msg_telemetry_responder #(
  parameter int unsigned CH_COUNT       = 16,
  parameter int unsigned CH_WIDTH       = 32,
  parameter int unsigned BYTES_PER_CH   = 4,
  parameter int unsigned WAYPOINT_COUNT = 8,
  parameter int unsigned CMD_WAY_BASE   = 1,
  parameter int unsigned CMD_STOP       = 9,
  parameter int unsigned CMD_BEGIN      = 10,
  parameter int unsigned CMD_TLM_BASE   = 20,
  parameter int unsigned CHECKSUM_EN    = 1
) (
  input  logic                                MESSAGE_INTERPRETER_CLOCK_50,
  input  logic                                MESSAGE_INTERPRETER_RESET_InHigh,
  input  logic                                RX_VALID_In,
  input  logic [7:0]                          RX_DATA_InBus,
  input  logic [CH_COUNT*CH_WIDTH-1:0]        TLM_InBus,
  output logic [7:0]                          TX_DATA_OutBus,
  output logic                                TX_VALID_Out,
  input  logic                                TX_READY_In,
  output logic [$clog2(WAYPOINT_COUNT)-1:0]   WAYSELECT_OutBus,
  output logic                                STOPSIGNAL_OutLow,
  output logic                                BEGINSIGNAL_OutLow,
  output logic                                BUSY_Out,
  output logic                                ERR_Out,
  output logic                                OVERRUN_Out
);

  localparam int unsigned WS_W  = $clog2(WAYPOINT_COUNT);
  localparam int unsigned SH_W  = 8 * BYTES_PER_CH;
  // Bits actually copied from a channel; the rest of the snapshot is zero.
  localparam int unsigned CP_W  = (CH_WIDTH < SH_W) ? CH_WIDTH : SH_W;
  localparam int unsigned CNT_W = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    CSUM
  } state_t;

  logic clk;
  logic rst;
  assign clk = MESSAGE_INTERPRETER_CLOCK_50;
  assign rst = MESSAGE_INTERPRETER_RESET_InHigh;

  state_t state, state_nxt;

  logic [SH_W-1:0]  shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       csum, csum_nxt;
  logic [7:0]       tx_data, tx_data_nxt;
  logic [WS_W-1:0]  way, way_nxt;
  logic             stop_n, stop_nxt;
  logic             begin_n, begin_nxt;
  logic             err, err_nxt;
  logic             ovr, ovr_nxt;

  // Command classification
  int unsigned code;
  logic        is_way;
  logic        is_stop;
  logic        is_begin;
  logic        is_tlm;

  assign code     = 32'(RX_DATA_InBus);
  assign is_way   = (code >= CMD_WAY_BASE) && (code < CMD_WAY_BASE + WAYPOINT_COUNT);
  assign is_stop  = (code == CMD_STOP);
  assign is_begin = (code == CMD_BEGIN);
  assign is_tlm   = (code >= CMD_TLM_BASE) && (code < CMD_TLM_BASE + CH_COUNT);

  // Channel snapshot: select the requested channel and fit it into the
  // shift register width (truncate or zero-extend).
  logic [CH_WIDTH-1:0] ch_word;
  logic [SH_W-1:0]     snap;

  always_comb begin
    ch_word = '0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      if (code == CMD_TLM_BASE + i) begin
        ch_word = TLM_InBus[i*CH_WIDTH +: CH_WIDTH];
      end
    end
    snap = '0;
    snap[CP_W-1:0] = ch_word[CP_W-1:0];
  end

  // Handshake and shift-register head
  logic       active;
  logic       fire;
  logic [7:0] sh_top;

  assign active = (state != IDLE);
  assign fire   = active && TX_READY_In;
  assign sh_top = shreg[SH_W-1 -: 8];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, reply datapath and control decode.
  // The reply path and the control path are evaluated side by side so a
  // control command landing mid-frame updates the levels on the same edge
  // as the byte advance without touching the frame registers.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    csum_nxt    = csum;
    tx_data_nxt = tx_data;
    way_nxt     = way;
    stop_nxt    = stop_n;
    begin_nxt   = begin_n;
    err_nxt     = 1'b0;
    ovr_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (RX_VALID_In && is_tlm && !is_way && !is_stop && !is_begin) begin
          shreg_nxt   = snap;
          tx_data_nxt = RX_DATA_InBus;
          csum_nxt    = RX_DATA_InBus;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        if (fire) begin
          tx_data_nxt = sh_top;
          csum_nxt    = csum + sh_top;
          shreg_nxt   = shreg << 8;
          cnt_nxt     = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          if (cnt == LAST_BYTE) begin
            if (CHECKSUM_EN != 0) begin
              tx_data_nxt = csum;
              state_nxt   = CSUM;
            end else begin
              tx_data_nxt = '0;
              state_nxt   = IDLE;
            end
          end else begin
            tx_data_nxt = sh_top;
            csum_nxt    = csum + sh_top;
            shreg_nxt   = shreg << 8;
            cnt_nxt     = cnt + CNT_W'(1);
          end
        end
      end
      CSUM: begin
        if (fire) begin
          tx_data_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (RX_VALID_In) begin
      if (is_way) begin
        way_nxt   = WS_W'(code - CMD_WAY_BASE);
        stop_nxt  = 1'b1;
        begin_nxt = 1'b1;
      end else if (is_stop) begin
        way_nxt   = '0;
        stop_nxt  = 1'b0;
        begin_nxt = 1'b1;
      end else if (is_begin) begin
        way_nxt   = '0;
        stop_nxt  = 1'b1;
        begin_nxt = 1'b0;
      end else if (is_tlm) begin
        // Any non-IDLE state counts as busy, including the cycle whose
        // final handshake is completing.
        ovr_nxt = active;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

  // Datapath and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      cnt     <= '0;
      csum    <= '0;
      tx_data <= '0;
      way     <= '0;
      stop_n  <= 1'b0;
      begin_n <= 1'b1;
      err     <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      csum    <= csum_nxt;
      tx_data <= tx_data_nxt;
      way     <= way_nxt;
      stop_n  <= stop_nxt;
      begin_n <= begin_nxt;
      err     <= err_nxt;
      ovr     <= ovr_nxt;
    end
  end

  assign TX_DATA_OutBus     = tx_data;
  assign TX_VALID_Out       = active;
  assign BUSY_Out           = active;
  assign WAYSELECT_OutBus   = way;
  assign STOPSIGNAL_OutLow  = stop_n;
  assign BEGINSIGNAL_OutLow = begin_n;
  assign ERR_Out            = err;
  assign OVERRUN_Out        = ovr;

endmodule

// File: tb/tb_msg_telemetry_responder.sv
// Testbench for msg_telemetry_responder: directed scenarios followed by
// randomized command/ready/telemetry traffic, checked every cycle against a
// frame-level reference model (queue of bytes still owed to the transmitter).
module tb_msg_telemetry_responder;

  localparam int unsigned CHN = 16;
  localparam int unsigned CHW = 32;
  localparam int unsigned BPC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [CHN*CHW-1:0] tlm_bus;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [2:0]        way_sel;
  logic              stop_n;
  logic              begin_n;
  logic              busy;
  logic              err;
  logic              ovr;

  always #10 clk = ~clk;

  msg_telemetry_responder #(
    .CH_COUNT      (CHN),
    .CH_WIDTH      (CHW),
    .BYTES_PER_CH  (BPC),
    .WAYPOINT_COUNT(8),
    .CMD_WAY_BASE  (1),
    .CMD_STOP      (9),
    .CMD_BEGIN     (10),
    .CMD_TLM_BASE  (20),
    .CHECKSUM_EN   (1)
  ) dut (
    .MESSAGE_INTERPRETER_CLOCK_50    (clk),
    .MESSAGE_INTERPRETER_RESET_InHigh(rst),
    .RX_VALID_In                     (rx_valid),
    .RX_DATA_InBus                   (rx_data),
    .TLM_InBus                       (tlm_bus),
    .TX_DATA_OutBus                  (tx_data),
    .TX_VALID_Out                    (tx_valid),
    .TX_READY_In                     (tx_ready),
    .WAYSELECT_OutBus                (way_sel),
    .STOPSIGNAL_OutLow               (stop_n),
    .BEGINSIGNAL_OutLow              (begin_n),
    .BUSY_Out                        (busy),
    .ERR_Out                         (err),
    .OVERRUN_Out                     (ovr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes the DUT still owes (front = byte on the bus),
  // plus the expected control levels and pulses.
  byte unsigned q[$];
  logic [2:0]   m_way;
  logic         m_stop_n;
  logic         m_begin_n;
  logic         m_err;
  logic         m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_way     = '0;
    m_stop_n  = 1'b0;
    m_begin_n = 1'b1;
    m_err     = 1'b0;
    m_ovr     = 1'b0;
  endtask

  // Effect of one clock edge given the inputs presented before it.
  task automatic model_step(input logic rxv, input logic [7:0] rxd, input logic rdy);
    bit           was_busy;
    int           code;
    logic [CHW-1:0] v;
    byte unsigned b;
    byte unsigned sum;
    was_busy = (q.size() != 0);
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (was_busy && rdy) void'(q.pop_front());
    if (rxv) begin
      code = int'(rxd);
      if (code >= 1 && code <= 8) begin
        m_way = 3'(code - 1); m_stop_n = 1'b1; m_begin_n = 1'b1;
      end else if (code == 9) begin
        m_way = '0; m_stop_n = 1'b0; m_begin_n = 1'b1;
      end else if (code == 10) begin
        m_way = '0; m_stop_n = 1'b1; m_begin_n = 1'b0;
      end else if (code >= 20 && code < 20 + int'(CHN)) begin
        if (was_busy) begin
          m_ovr = 1'b1;
        end else begin
          v   = tlm_bus[(code-20)*int'(CHW) +: CHW];
          sum = byte'(code);
          q.push_back(byte'(code));
          for (int k = int'(BPC) - 1; k >= 0; k--) begin
            b   = byte'(v >> (8*k));
            sum = byte'(sum + b);
            q.push_back(b);
          end
          q.push_back(sum);
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    check("busy",     32'(busy),     32'(q.size() != 0));
    if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
    check("waysel",   32'(way_sel),  32'(m_way));
    check("stop_n",   32'(stop_n),   32'(m_stop_n));
    check("begin_n",  32'(begin_n),  32'(m_begin_n));
    check("err",      32'(err),      32'(m_err));
    check("overrun",  32'(ovr),      32'(m_ovr));
  endtask

  // One clock: drive inputs (called at a falling edge), predict, clock,
  // then compare at the next falling edge.
  task automatic step(input logic rxv, input logic [7:0] rxd, input logic rdy);
    rx_valid = rxv;
    rx_data  = rxd;
    tx_ready = rdy;
    model_step(rxv, rxd, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    tlm_bus  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check("reset_tx_data", 32'(tx_data), 32'h0);
    rst = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Control commands
    step(1'b1, 8'h05, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    step(1'b1, 8'h09, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Telemetry frame with READY held high
    tlm_bus[31:0] = 32'h0A0B0C0D;
    step(1'b1, 8'h14, 1'b1);
    repeat (7) step(1'b0, 8'h00, 1'b1);

    // Same request, READY toggling, channel changed after accept
    step(1'b1, 8'h14, 1'b0);
    tlm_bus[31:0] = 32'hFFFFFFFF;
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'(i % 2));

    // Overrun, control and unknown command mid-frame
    tlm_bus[31:0] = 32'h0A0B0C0D;
    step(1'b1, 8'h14, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h15, 1'b1);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'hC8, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Request landing on the final handshake is dropped; next one is taken
    step(1'b1, 8'h17, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h16, 1'b1);
    step(1'b1, 8'h16, 1'b1);
    repeat (7) step(1'b0, 8'h00, 1'b1);

    // Reset after the 2nd data byte has transferred
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h14, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_valid", 32'(tx_valid), 32'h0);
    check("rst_mid_busy",  32'(busy),     32'h0);
    check("rst_mid_stop",  32'(stop_n),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h14, 1'b1);
    repeat (7) step(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [7:0]  code;
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < int'(CHN); c++) tlm_bus[c*int'(CHW) +: CHW] = $urandom();
      end
      r = $urandom_range(0, 9);
      if (r < 4)      code = 8'(20 + $urandom_range(0, CHN - 1));
      else if (r < 7) code = 8'($urandom_range(1, 10));
      else            code = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 2) == 0), code, 1'($urandom_range(0, 2) != 0));
    end
    repeat (10) step(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_telemetry_responder.md
Name: msg_telemetry_responder

Overview:
- Parametrised successor of the single-byte message interpreter.
- Decodes 8-bit command bytes from the UART receive path into waypoint select, stop and begin controls.
- Serves telemetry read requests by snapshotting one of CH_COUNT flat-packed channels and streaming a framed multi-byte reply over a valid/ready byte interface to the UART transmitter.
- Sits between the UART RX/TX blocks and the odometry, motor, distance and IMU datapaths.

Parameters:
- CH_COUNT, 16: number of telemetry channels on TLM_InBus.
- CH_WIDTH, 32: width of each channel in bits.
- BYTES_PER_CH, 4: data bytes sent per reply (1..8). The low 8*BYTES_PER_CH bits are sent, zero-extended if CH_WIDTH is smaller.
- WAYPOINT_COUNT, 8: number of waypoints (power of 2, >=2). WS_W = clog2(WAYPOINT_COUNT).
- CMD_WAY_BASE, 1: code for waypoint 0. Codes CMD_WAY_BASE..CMD_WAY_BASE+WAYPOINT_COUNT-1 are waypoint codes.
- CMD_STOP, 9: stop command code.
- CMD_BEGIN, 10: begin command code.
- CMD_TLM_BASE, 20: code for channel 0. Codes CMD_TLM_BASE..CMD_TLM_BASE+CH_COUNT-1 are telemetry codes.
- CHECKSUM_EN, 1: when 1, append a trailing checksum byte.

Ports:
- MESSAGE_INTERPRETER_CLOCK_50  in  1  system clock, 50 MHz.
- MESSAGE_INTERPRETER_RESET_InHigh  in  1  asynchronous active-high reset.
- RX_VALID_In  in  1  one-cycle strobe; RX_DATA_InBus is valid this cycle.
- RX_DATA_InBus  in  8  received command byte.
- TLM_InBus  in  CH_COUNT*CH_WIDTH  channel i occupies bits [i*CH_WIDTH +: CH_WIDTH].
- TX_DATA_OutBus  out  8  reply byte.
- TX_VALID_Out  out  1  reply byte valid.
- TX_READY_In  in  1  transmitter accepts the byte.
- WAYSELECT_OutBus  out  WS_W  selected waypoint index.
- STOPSIGNAL_OutLow  out  1  stop, active low.
- BEGINSIGNAL_OutLow  out  1  begin, active low.
- BUSY_Out  out  1  high while a reply is in progress.
- ERR_Out  out  1  one-cycle pulse on an unknown command code.
- OVERRUN_Out  out  1  one-cycle pulse when a telemetry request is dropped.

Behaviour:
- Reset values: WAYSELECT 0, STOPSIGNAL 0 (robot starts stopped), BEGINSIGNAL 1, TX_VALID 0, TX_DATA 0x00, BUSY 0, ERR 0, OVERRUN 0. FSM returns to IDLE.
- Reset mid-reply aborts the frame immediately. No partial byte remains valid.
- Commands are sampled only on the rising clock edge where RX_VALID_In=1. All control outputs are registered and update one edge after acceptance.
- Waypoint code c: WAYSELECT = c-CMD_WAY_BASE, STOP=1, BEGIN=1.
- CMD_STOP: WAYSELECT=0, STOP=0, BEGIN=1.
- CMD_BEGIN: WAYSELECT=0, STOP=1, BEGIN=0.
- STOP and BEGIN are levels. They hold until the next control command.
- Control commands are processed in any FSM state, including mid-reply, and never disturb the reply in progress.
- Unknown code (not waypoint, stop, begin or telemetry): ERR_Out pulses for one cycle. All other state is unchanged.
- Telemetry code in IDLE:
  - On the accept edge, snapshot the channel's low 8*BYTES_PER_CH bits into a shift register.
  - Load the header byte (the command code) onto TX_DATA.
  - Set TX_VALID=1 and BUSY=1 on the next cycle.
  - Later changes to TLM_InBus do not affect the frame.
- Telemetry code while BUSY=1: the request is dropped and OVERRUN_Out pulses for one cycle. This includes the cycle of the final handshake.
- FSM states: IDLE -> HDR -> DATA (byte counter 0..BYTES_PER_CH-1, MSB byte first) -> CSUM (only if CHECKSUM_EN) -> IDLE.
- A transfer occurs on an edge where TX_VALID=1 and TX_READY=1.
- Each transfer advances exactly one byte. TX_DATA is stable while TX_VALID=1 and TX_READY=0.
- Back-to-back READY gives one byte per clock, no bubbles inside a frame.
- After the last byte transfers, the FSM returns to IDLE, and TX_VALID and BUSY are 0 the next cycle. A new request is accepted from that cycle on.
- Checksum = 8-bit sum modulo 256 of the header and all data bytes. Carries are discarded.
- Frame length = 1 + BYTES_PER_CH + CHECKSUM_EN bytes.
- Simultaneous RX_VALID and TX handshake are handled independently. Control-output updates and the TX byte advance occur on the same edge.

Test Plan:
- Reset, then no stimulus -> WAYSELECT=0, STOP=0, BEGIN=1, TX_VALID=0, BUSY=0.
- RX 0x05 then 0x0A -> WAYSELECT=4, STOP=1, BEGIN=1 after the first edge; then WAYSELECT=0, BEGIN=0 after the second. RX 0x09 -> STOP=0, BEGIN=1.
- Channel 0 = 0x0A0B0C0D, TX_READY held high, RX 0x14 -> TX bytes 0x14, 0x0A, 0x0B, 0x0C, 0x0D, 0x42 on 6 consecutive cycles starting 1 cycle after accept; BUSY drops the cycle after 0x42.
- Same request with TX_READY toggled 0/1 each cycle and channel 0 changed to 0xFFFFFFFF after accept -> identical byte sequence; bytes held stable while READY=0.
- During a reply, RX 0x15 -> OVERRUN pulses 1 cycle and the frame is unaffected. RX 0x03 mid-frame -> WAYSELECT=2 with no frame corruption. RX 0xC8 -> ERR pulses 1 cycle.
- Assert reset after the 2nd data byte -> TX_VALID=0 and BUSY=0 immediately, STOP=0; a fresh RX 0x14 then yields a complete frame.
